// File: rtl/sram_fe_2048x39.sv
// Request/response front end for a 2048x39 synchronous RAM with a credit-gated response FIFO.
// Define SRAM_FE_SKID_EN for a 3-deep skid FIFO (full read rate); otherwise the FIFO is 1 deep.
module sram_fe_2048x39 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [10:0] req_addr,
    input  logic [38:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [38:0] rsp_rdata,
    output logic [10:0] mem_adr,
    output logic [38:0] mem_d,
    output logic        mem_we,
    input  logic [38:0] mem_q,
    output logic [1:0]  rsp_occ
);

`ifdef SRAM_FE_SKID_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif

    localparam logic [1:0] LAST = 2'(D - 1);

    logic [1:0]  r_occ;
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic        r_pend;
    logic [38:0] r_fifo [4];

    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_credit;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Ready looks only at registered state, so an in-flight read always has a slot.
    assign w_credit  = {1'b0, r_occ} + {2'b00, r_pend};
    assign req_ready = ~RST & (w_credit < 3'(D));
    assign w_accept  = req_valid & req_ready;

    assign mem_adr = req_addr;
    assign mem_d   = req_wdata;
    assign mem_we  = w_accept & req_we;

    assign w_push    = r_pend;
    assign rsp_valid = (r_occ != 2'd0);
    assign w_pop     = rsp_valid & rsp_ready;
    assign rsp_rdata = rsp_valid ? r_fifo[r_rptr] : '0;
    assign rsp_occ   = r_occ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_occ  <= 2'd0;
            r_pend <= 1'b0;
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
        end else begin
            r_pend <= w_accept & ~req_we;
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage needs no reset; the output is masked while empty.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wptr] <= mem_q;
        end
    end

endmodule

// File: tb/tb_sram_fe_2048x39.sv
// Scoreboard bench for sram_fe_2048x39 with a behavioural 2048x39 RAM behind it.
// Depth-dependent expectations follow SRAM_FE_SKID_EN.
module tb_sram_fe_2048x39;

`ifdef SRAM_FE_SKID_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif
    localparam int GAP = (D == 3) ? 1 : 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [10:0] req_addr = '0;
    logic [38:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [38:0] rsp_rdata;
    logic [10:0] mem_adr;
    logic [38:0] mem_d;
    logic        mem_we;
    logic [38:0] mem_q;
    logic [1:0]  rsp_occ;

    int n_chk = 0;
    int n_fail = 0;
    int n_rsp = 0;
    int cyc = 0;

    logic [38:0] exp_q [$];
    logic [38:0] shadow [2048];
    logic [38:0] ram [2048];

    sram_fe_2048x39 dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_adr   (mem_adr),
        .mem_d     (mem_d),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .rsp_occ   (rsp_occ)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    function automatic logic [38:0] pat(input int a);
        return {11'(a), 28'(a) ^ 28'h5A5A5A5};
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ram[i] = pat(i);
            shadow[i] = pat(i);
        end
    end

    always @(posedge CLK) begin
        if (mem_we) ram[mem_adr] <= mem_d;
        mem_q <= ram[mem_adr];
    end

    task automatic chk(input string nm, input logic [38:0] act, input logic [38:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %h expected no response", rsp_rdata);
            end else begin
                chk("rsp_data", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic we, input logic [10:0] a,
                       input logic [38:0] d, output int acc);
        logic ok;
        ok = 1'b0;
        acc = -1;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge CLK);
            if (req_ready) begin
                ok = 1'b1;
                acc = cyc;
                chk("mem_we_accept", 39'(mem_we), 39'(we));
                chk("mem_adr", 39'(mem_adr), 39'(a));
                if (we) shadow[a] = d;
                else exp_q.push_back(shadow[a]);
            end else begin
                chk("mem_we_stalled", 39'(mem_we), 39'd0);
            end
            step();
        end
        req_valid = 1'b0;
        req_we = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_timeout: got no accept expected accept addr %h", a);
        end
    endtask

    task automatic stall_reads(input int cycles, input int base, output int cnt);
        int a;
        a = base;
        cnt = 0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 11'(a);
        for (int n = 0; n < cycles; n++) begin
            @(negedge CLK);
            if (req_ready) begin
                cnt++;
                exp_q.push_back(shadow[a]);
                a++;
            end
            step();
            req_addr = 11'(a);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) step();
        chk("drain_left", 39'(exp_q.size()), 39'd0);
        chk("drain_valid", 39'(rsp_valid), 39'd0);
        chk("drain_occ", 39'(rsp_occ), 39'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        int cnt;
        int n0;

        req_valid = 1'b1;
        req_we = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", 39'(req_ready), 39'd0);
        chk("rst_mem_we", 39'(mem_we), 39'd0);
        chk("rst_valid", 39'(rsp_valid), 39'd0);
        chk("rst_occ", 39'(rsp_occ), 39'd0);
        chk("rst_rdata", rsp_rdata, 39'd0);
        req_valid = 1'b0;
        req_we = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", 39'(req_ready), 39'd1);
        step();

        rsp_ready = 1'b1;
        req(1'b1, 11'h005, 39'h12_3456_789A, acc);
        req(1'b0, 11'h005, 39'h0, acc);
        @(negedge CLK);
        chk("lat_t1_valid", 39'(rsp_valid), 39'd0);
        chk("lat_t1_we", 39'(mem_we), 39'd0);
        step();
        @(negedge CLK);
        chk("lat_t2_valid", 39'(rsp_valid), 39'd1);
        chk("lat_t2_data", rsp_rdata, 39'h12_3456_789A);
        step();
        drain();

        n0 = n_rsp;
        prev = 0;
        for (int a = 0; a < 16; a++) begin
            req(1'b0, 11'(a), 39'h0, acc);
            if (a > 0) chk("burst_gap", 39'(acc - prev), 39'(GAP));
            prev = acc;
        end
        drain();
        chk("burst_count", 39'(n_rsp - n0), 39'd16);

        rsp_ready = 1'b0;
        stall_reads(8, 32, cnt);
        chk("stall_accepts", 39'(cnt), 39'(D));
        @(negedge CLK);
        chk("stall_ready", 39'(req_ready), 39'd0);
        chk("stall_occ", 39'(rsp_occ), 39'(D));
        chk("stall_head", rsp_rdata, exp_q[0]);
        for (int n = 0; n < 3; n++) begin
            step();
            @(negedge CLK);
            chk("stall_hold", rsp_rdata, exp_q[0]);
        end
        step();

        req_we = 1'b1;
        req_addr = 11'h7FF;
        req_wdata = 39'h55_AAAA_5555;
        for (int n = 0; n < 2; n++) begin
            @(negedge CLK);
            chk("wr_blocked", 39'(mem_we), 39'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        chk("wr_before_pop", 39'(mem_we), 39'd0);
        step();
        @(negedge CLK);
        chk("wr_after_pop", 39'(mem_we), 39'd1);
        shadow[11'h7FF] = 39'h55_AAAA_5555;
        step();
        req_valid = 1'b0;
        req_we = 1'b0;
        drain();
        req(1'b0, 11'h7FF, 39'h0, acc);
        drain();

        rsp_ready = 1'b0;
        stall_reads(3, 100, cnt);
        req_valid = 1'b0;
        chk("pre_rst_occ", 39'(rsp_occ), 39'((D == 3) ? 2 : 1));
        RST = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", 39'(rsp_valid), 39'd0);
        chk("mid_rst_occ", 39'(rsp_occ), 39'd0);
        chk("mid_rst_ready", 39'(req_ready), 39'd0);
        step();
        RST = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) step();
        chk("post_rst_occ", 39'(rsp_occ), 39'd0);
        req(1'b0, 11'h005, 39'h0, acc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
